// File: rtl/hssi_lane_reset_seq.sv
// Reset/initialisation sequencer for HSSI lanes: one shared TX FSM plus an independent RX FSM per lane.
// Optional per-lane relock counters are enabled by defining HSSI_RESET_SEQ_RELOCK_CNT_EN.
module hssi_lane_reset_seq #(
   parameter int NUM_LN       = 4,
   parameter int T_PLL_STABLE = 64,
   parameter int T_TX_DIG     = 32,
   parameter int T_LTD_STABLE = 128,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_start,
   output logic              init_done,
   input  logic [NUM_LN-1:0] lane_rst_req,
   input  logic              tx_pll_locked,
   input  logic              tx_cal_busy,
   input  logic              rx_cal_busy,
   input  logic [NUM_LN-1:0] rx_is_lockedtodata,
   output logic [NUM_LN-1:0] tx_analogreset,
   output logic [NUM_LN-1:0] tx_digitalreset,
   output logic [NUM_LN-1:0] rx_analogreset,
   output logic [NUM_LN-1:0] rx_digitalreset,
   output logic              tx_ready,
   output logic [NUM_LN-1:0] rx_ready
`ifdef HSSI_RESET_SEQ_RELOCK_CNT_EN
   ,
   output logic [NUM_LN*8-1:0] relock_cnt
`endif
);

   localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(T_PLL_STABLE - 1);
   localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(T_TX_DIG - 1);
   localparam logic [CNT_W-1:0] LTD_LAST = CNT_W'(T_LTD_STABLE - 1);

   generate
      if (NUM_LN < 1 || NUM_LN > 16) begin : g_chk_ln
         $error("hssi_lane_reset_seq: NUM_LN must be 1..16");
      end
      if (T_PLL_STABLE < 1 || T_TX_DIG < 1 || T_LTD_STABLE < 1) begin : g_chk_t
         $error("hssi_lane_reset_seq: timer values must be at least 1");
      end
      if ((longint'(1) << CNT_W) <= longint'(T_PLL_STABLE) ||
          (longint'(1) << CNT_W) <= longint'(T_TX_DIG) ||
          (longint'(1) << CNT_W) <= longint'(T_LTD_STABLE)) begin : g_chk_w
         $error("hssi_lane_reset_seq: CNT_W too narrow for the timer values");
      end
   endgenerate

   typedef enum logic [1:0] {TX_RESET = 2'd0, TX_ANA_REL = 2'd1, TX_READY = 2'd2} tx_state_t;
   typedef enum logic [1:0] {RX_RESET = 2'd0, RX_WAIT_LTD = 2'd1, RX_READY = 2'd2} rx_state_t;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic [2:0]        cm_s1, cm_s2;
   logic [NUM_LN-1:0] ltd_s1, ltd_s2;
   logic              pll_sync, tx_cal_sync, rx_cal_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cm_s1  <= '0;
         cm_s2  <= '0;
         ltd_s1 <= '0;
         ltd_s2 <= '0;
      end else begin
         cm_s1  <= {rx_cal_busy, tx_cal_busy, tx_pll_locked};
         cm_s2  <= cm_s1;
         ltd_s1 <= rx_is_lockedtodata;
         ltd_s2 <= ltd_s1;
      end
   end

   assign pll_sync    = cm_s2[0];
   assign tx_cal_sync = cm_s2[1];
   assign rx_cal_sync = cm_s2[2];

   tx_state_t        tx_state, tx_state_nx;
   logic [CNT_W-1:0] tx_cnt, tx_cnt_nx;
   rx_state_t        rx_state    [NUM_LN];
   rx_state_t        rx_state_nx [NUM_LN];
   logic [CNT_W-1:0] rx_cnt      [NUM_LN];
   logic [CNT_W-1:0] rx_cnt_nx   [NUM_LN];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_RESET;
         tx_cnt   <= '0;
         for (int i = 0; i < NUM_LN; i++) begin
            rx_state[i] <= RX_RESET;
            rx_cnt[i]   <= '0;
         end
      end else begin
         tx_state <= tx_state_nx;
         tx_cnt   <= tx_cnt_nx;
         for (int i = 0; i < NUM_LN; i++) begin
            rx_state[i] <= rx_state_nx[i];
            rx_cnt[i]   <= rx_cnt_nx[i];
         end
      end
   end

   always_comb begin
      tx_state_nx = tx_state;
      tx_cnt_nx   = tx_cnt;
      if (init_start) begin
         tx_state_nx = TX_RESET;
         tx_cnt_nx   = '0;
      end else begin
         case (tx_state)
            TX_RESET: begin
               if (!pll_sync || tx_cal_sync) begin
                  tx_cnt_nx = '0;
               end else if (tx_cnt == PLL_LAST) begin
                  tx_state_nx = TX_ANA_REL;
                  tx_cnt_nx   = '0;
               end else begin
                  tx_cnt_nx = cnt_inc(tx_cnt);
               end
            end
            TX_ANA_REL: begin
               if (!pll_sync) begin
                  tx_state_nx = TX_RESET;
                  tx_cnt_nx   = '0;
               end else if (tx_cnt == DIG_LAST) begin
                  tx_state_nx = TX_READY;
                  tx_cnt_nx   = '0;
               end else begin
                  tx_cnt_nx = cnt_inc(tx_cnt);
               end
            end
            TX_READY: begin
               if (!pll_sync) begin
                  tx_state_nx = TX_RESET;
                  tx_cnt_nx   = '0;
               end
            end
            default: begin
               tx_state_nx = TX_RESET;
               tx_cnt_nx   = '0;
            end
         endcase
      end
   end

   // A low tx_ready holds every lane in RX_RESET, which also covers the tx_ready falling edge.
   always_comb begin
      for (int i = 0; i < NUM_LN; i++) begin
         rx_state_nx[i] = rx_state[i];
         rx_cnt_nx[i]   = rx_cnt[i];
         if (init_start || lane_rst_req[i] || !tx_ready) begin
            rx_state_nx[i] = RX_RESET;
            rx_cnt_nx[i]   = '0;
         end else begin
            case (rx_state[i])
               RX_RESET: begin
                  if (!rx_cal_sync) begin
                     rx_state_nx[i] = RX_WAIT_LTD;
                     rx_cnt_nx[i]   = '0;
                  end
               end
               RX_WAIT_LTD: begin
                  if (!ltd_s2[i]) begin
                     rx_cnt_nx[i] = '0;
                  end else if (rx_cnt[i] == LTD_LAST) begin
                     rx_state_nx[i] = RX_READY;
                     rx_cnt_nx[i]   = '0;
                  end else begin
                     rx_cnt_nx[i] = cnt_inc(rx_cnt[i]);
                  end
               end
               RX_READY: begin
                  if (!ltd_s2[i]) begin
                     rx_state_nx[i] = RX_RESET;
                     rx_cnt_nx[i]   = '0;
                  end
               end
               default: begin
                  rx_state_nx[i] = RX_RESET;
                  rx_cnt_nx[i]   = '0;
               end
            endcase
         end
      end
   end

   logic              tx_ana_d, tx_dig_d, tx_rdy_d;
   logic [NUM_LN-1:0] rx_ana_d, rx_dig_d, rx_rdy_d;

   always_comb begin
      tx_ana_d = 1'b1;
      tx_dig_d = 1'b1;
      tx_rdy_d = 1'b0;
      case (tx_state)
         TX_ANA_REL: tx_ana_d = 1'b0;
         TX_READY: begin
            tx_ana_d = 1'b0;
            tx_dig_d = 1'b0;
            tx_rdy_d = 1'b1;
         end
         default: ;
      endcase
      rx_ana_d = '1;
      rx_dig_d = '1;
      rx_rdy_d = '0;
      for (int i = 0; i < NUM_LN; i++) begin
         case (rx_state[i])
            RX_WAIT_LTD: rx_ana_d[i] = 1'b0;
            RX_READY: begin
               rx_ana_d[i] = 1'b0;
               rx_dig_d[i] = 1'b0;
               rx_rdy_d[i] = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // init_start forces the reset levels on the same edge that resets the FSMs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_analogreset  <= '1;
         tx_digitalreset <= '1;
         rx_analogreset  <= '1;
         rx_digitalreset <= '1;
         tx_ready        <= 1'b0;
         rx_ready        <= '0;
         init_done       <= 1'b0;
      end else if (init_start) begin
         tx_analogreset  <= '1;
         tx_digitalreset <= '1;
         rx_analogreset  <= '1;
         rx_digitalreset <= '1;
         tx_ready        <= 1'b0;
         rx_ready        <= '0;
         init_done       <= 1'b0;
      end else begin
         tx_analogreset  <= {NUM_LN{tx_ana_d}};
         tx_digitalreset <= {NUM_LN{tx_dig_d}};
         rx_analogreset  <= rx_ana_d;
         rx_digitalreset <= rx_dig_d;
         tx_ready        <= tx_rdy_d;
         rx_ready        <= rx_rdy_d;
         init_done       <= tx_ready & (&rx_ready);
      end
   end

`ifdef HSSI_RESET_SEQ_RELOCK_CNT_EN
   logic [7:0] relock [NUM_LN];

   // Only a lane's own lock loss counts; restarts and TX-driven drops do not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LN; i++) relock[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_LN; i++) begin
            if (init_start) begin
               relock[i] <= '0;
            end else if (rx_state[i] == RX_READY && !lane_rst_req[i] && tx_ready &&
                         !ltd_s2[i] && relock[i] != 8'hFF) begin
               relock[i] <= relock[i] + 8'd1;
            end
         end
      end
   end

   always_comb begin
      relock_cnt = '0;
      for (int i = 0; i < NUM_LN; i++) relock_cnt[i*8 +: 8] = relock[i];
   end
`endif

endmodule

// File: tb/tb_hssi_lane_reset_seq.sv
// Bench for hssi_lane_reset_seq: directed bring-up/fault steps plus randomised lock disturbances,
// every cycle compared against a pin-history reference model.
module tb_hssi_lane_reset_seq;
   localparam int NL    = 4;
   localparam int T_PLL = 8;
   localparam int T_DIG = 4;
   localparam int T_LTD = 16;
   localparam int HMAX  = 16384;

   logic          clk;
   logic          rst_n;
   logic          init_start;
   logic          init_done;
   logic [NL-1:0] lane_rst_req;
   logic          tx_pll_locked;
   logic          tx_cal_busy;
   logic          rx_cal_busy;
   logic [NL-1:0] ltd;
   logic [NL-1:0] tx_analogreset;
   logic [NL-1:0] tx_digitalreset;
   logic [NL-1:0] rx_analogreset;
   logic [NL-1:0] rx_digitalreset;
   logic          tx_ready;
   logic [NL-1:0] rx_ready;
`ifdef HSSI_RESET_SEQ_RELOCK_CNT_EN
   logic [NL*8-1:0] relock_cnt;
`endif

   hssi_lane_reset_seq #(
      .NUM_LN(NL), .T_PLL_STABLE(T_PLL), .T_TX_DIG(T_DIG), .T_LTD_STABLE(T_LTD), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(init_done),
      .lane_rst_req(lane_rst_req), .tx_pll_locked(tx_pll_locked), .tx_cal_busy(tx_cal_busy),
      .rx_cal_busy(rx_cal_busy), .rx_is_lockedtodata(ltd),
      .tx_analogreset(tx_analogreset), .tx_digitalreset(tx_digitalreset),
      .rx_analogreset(rx_analogreset), .rx_digitalreset(rx_digitalreset),
      .tx_ready(tx_ready), .rx_ready(rx_ready)
`ifdef HSSI_RESET_SEQ_RELOCK_CNT_EN
      , .relock_cnt(relock_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model: pin history indexed by edges since reset release, plus phase/run counters.
   int        j;
   bit        pll_h  [HMAX];
   bit        txcb_h [HMAX];
   bit        rxcb_h [HMAX];
   bit [NL-1:0] ltd_h [HMAX];
   int        tx_ph, tx_run;
   int        rx_ph  [NL];
   int        rx_run [NL];
   int        m_relock [NL];
   bit        m_tx_ana, m_tx_dig, m_tx_rdy, m_done;
   bit [NL-1:0] m_rx_ana, m_rx_dig, m_rx_rdy;

   task automatic model_reset();
      j = 0;
      tx_ph = 0;
      tx_run = 0;
      for (int i = 0; i < NL; i++) begin
         rx_ph[i] = 0;
         rx_run[i] = 0;
         m_relock[i] = 0;
      end
      m_tx_ana = 1; m_tx_dig = 1; m_tx_rdy = 0; m_done = 0;
      m_rx_ana = '1; m_rx_dig = '1; m_rx_rdy = '0;
   endtask

   task automatic model_edge();
      bit sp, stc, src, txr;
      bit [NL-1:0] sl;
      bit n_tx_ana, n_tx_dig, n_tx_rdy, n_done;
      bit [NL-1:0] n_rx_ana, n_rx_dig, n_rx_rdy;
      j++;
      pll_h[j] = tx_pll_locked;
      txcb_h[j] = tx_cal_busy;
      rxcb_h[j] = rx_cal_busy;
      ltd_h[j] = ltd;
      if (j >= 3) begin
         sp = pll_h[j-2]; stc = txcb_h[j-2]; src = rxcb_h[j-2]; sl = ltd_h[j-2];
      end else begin
         sp = 0; stc = 0; src = 0; sl = '0;
      end
      txr = m_tx_rdy;
      if (init_start) begin
         n_tx_ana = 1; n_tx_dig = 1; n_tx_rdy = 0; n_done = 0;
         n_rx_ana = '1; n_rx_dig = '1; n_rx_rdy = '0;
      end else begin
         n_tx_ana = (tx_ph == 0);
         n_tx_dig = (tx_ph != 2);
         n_tx_rdy = (tx_ph == 2);
         for (int i = 0; i < NL; i++) begin
            n_rx_ana[i] = (rx_ph[i] == 0);
            n_rx_dig[i] = (rx_ph[i] != 2);
            n_rx_rdy[i] = (rx_ph[i] == 2);
         end
         n_done = m_tx_rdy & (&m_rx_rdy);
      end
      if (init_start) begin
         tx_ph = 0; tx_run = 0;
      end else if (tx_ph == 0) begin
         if (sp && !stc) begin
            tx_run++;
            if (tx_run == T_PLL) begin tx_ph = 1; tx_run = 0; end
         end else tx_run = 0;
      end else if (!sp) begin
         tx_ph = 0; tx_run = 0;
      end else if (tx_ph == 1) begin
         tx_run++;
         if (tx_run == T_DIG) tx_ph = 2;
      end
      for (int i = 0; i < NL; i++) begin
         if (init_start) begin
            rx_ph[i] = 0; rx_run[i] = 0; m_relock[i] = 0;
         end else if (lane_rst_req[i] || !txr) begin
            rx_ph[i] = 0; rx_run[i] = 0;
         end else if (rx_ph[i] == 0) begin
            if (!src) begin rx_ph[i] = 1; rx_run[i] = 0; end
         end else if (rx_ph[i] == 1) begin
            if (sl[i]) begin
               rx_run[i]++;
               if (rx_run[i] == T_LTD) rx_ph[i] = 2;
            end else rx_run[i] = 0;
         end else if (!sl[i]) begin
            rx_ph[i] = 0;
            if (m_relock[i] < 255) m_relock[i]++;
         end
      end
      m_tx_ana = n_tx_ana; m_tx_dig = n_tx_dig; m_tx_rdy = n_tx_rdy; m_done = n_done;
      m_rx_ana = n_rx_ana; m_rx_dig = n_rx_dig; m_rx_rdy = n_rx_rdy;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("tx_analogreset", 32'(tx_analogreset), 32'({NL{m_tx_ana}}));
      chk("tx_digitalreset", 32'(tx_digitalreset), 32'({NL{m_tx_dig}}));
      chk("rx_analogreset", 32'(rx_analogreset), 32'(m_rx_ana));
      chk("rx_digitalreset", 32'(rx_digitalreset), 32'(m_rx_dig));
      chk("tx_ready", 32'(tx_ready), 32'(m_tx_rdy));
      chk("rx_ready", 32'(rx_ready), 32'(m_rx_rdy));
      chk("init_done", 32'(init_done), 32'(m_done));
`ifdef HSSI_RESET_SEQ_RELOCK_CNT_EN
      for (int i = 0; i < NL; i++) chk("relock_cnt", 32'(relock_cnt[i*8 +: 8]), 32'(m_relock[i]));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      cyc++;
      #1;
      check_all();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tx_ana"}, 32'(tx_analogreset), 32'hF);
      chk({tag, "_tx_dig"}, 32'(tx_digitalreset), 32'hF);
      chk({tag, "_rx_ana"}, 32'(rx_analogreset), 32'hF);
      chk({tag, "_rx_dig"}, 32'(rx_digitalreset), 32'hF);
      chk({tag, "_tx_rdy"}, 32'(tx_ready), 32'h0);
      chk({tag, "_rx_rdy"}, 32'(rx_ready), 32'h0);
      chk({tag, "_done"}, 32'(init_done), 32'h0);
   endtask

   task automatic wait_done(input int limit, input string tag);
      int n = 0;
      while (init_done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk(tag, 32'(init_done), 32'h1);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int r;
      int pll_lo, txc_hi, rxc_hi, n;
      int ltd_lo [NL];
      rst_n = 1'b0; init_start = 1'b0; lane_rst_req = '0;
      tx_pll_locked = 1'b0; tx_cal_busy = 1'b0; rx_cal_busy = 1'b0; ltd = '0;
      model_reset();
      repeat (3) tick();
      chk_reset_vals("reset");

      // Nominal bring-up: lock present from the first edge after release.
      rst_n = 1'b1; tx_pll_locked = 1'b1; ltd = '1;
      while (j < 10) tick();
      chk("nom_ana_hold", 32'(tx_analogreset), 32'hF);
      tick();
      chk("nom_ana_rel", 32'(tx_analogreset), 32'h0);
      chk("nom_dig_hold", 32'(tx_digitalreset), 32'hF);
      while (j < 14) tick();
      chk("nom_dig_hold2", 32'(tx_digitalreset), 32'hF);
      tick();
      chk("nom_dig_rel", 32'(tx_digitalreset), 32'h0);
      chk("nom_tx_ready", 32'(tx_ready), 32'h1);
      while (j < 32) tick();
      chk("nom_rx_not_yet", 32'(rx_ready), 32'h0);
      tick();
      chk("nom_rx_ready", 32'(rx_ready), 32'hF);
      chk("nom_done_lags", 32'(init_done), 32'h0);
      tick();
      chk("nom_done", 32'(init_done), 32'h1);

      // PLL glitch during the stability wait.
      apply_reset();
      tx_pll_locked = 1'b1;
      while (j < 4) tick();
      tx_pll_locked = 1'b0;
      tick();
      tx_pll_locked = 1'b1;
      r = j + 1;
      while (j < r + 9) tick();
      chk("glitch_ana_hold", 32'(tx_analogreset), 32'hF);
      tick();
      chk("glitch_ana_rel", 32'(tx_analogreset), 32'h0);
      wait_done(200, "glitch_bringup");

      // Lane 2 loses lock for three cycles.
      ltd[2] = 1'b0;
      repeat (3) tick();
      ltd[2] = 1'b1;
      r = j + 1;
      while (j < r + 17) tick();
      chk("l2_down", 32'(rx_ready[2]), 32'h0);
      chk("l2_rxdig", 32'(rx_digitalreset[2]), 32'h1);
      chk("l013_up", 32'({rx_ready[3], rx_ready[1:0]}), 32'h7);
      chk("l2_done_low", 32'(init_done), 32'h0);
      tick();
      chk("l2_up", 32'(rx_ready), 32'hF);
      tick();
      chk("l2_done_back", 32'(init_done), 32'h1);
`ifdef HSSI_RESET_SEQ_RELOCK_CNT_EN
      chk("l2_relock", 32'(relock_cnt[23:16]), 32'h1);
`endif

      // init_start together with lane_rst_req[1] while fully ready.
      init_start = 1'b1; lane_rst_req = 4'b0010;
      tick();
      init_start = 1'b0; lane_rst_req = '0;
      chk_reset_vals("restart");
`ifdef HSSI_RESET_SEQ_RELOCK_CNT_EN
      chk("restart_relock", 32'(relock_cnt), 32'h0);
`endif
      wait_done(200, "restart_bringup");

      // Asynchronous reset while TX analog is released.
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      n = 0;
      while (tx_analogreset[0] !== 1'b0 && n < 50) begin tick(); n++; end
      chk("reach_ana_rel", 32'({tx_analogreset, tx_digitalreset}), 32'h0F);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
      while (j < 10) tick();
      chk("post_rst_ana_hold", 32'(tx_analogreset), 32'hF);
      tick();
      chk("post_rst_ana_rel", 32'(tx_analogreset), 32'h0);
      wait_done(200, "post_rst_bringup");

      // Randomised disturbances.
      pll_lo = 0; txc_hi = 0; rxc_hi = 0;
      for (int i = 0; i < NL; i++) ltd_lo[i] = 0;
      for (int c = 0; c < 2000; c++) begin
         init_start = ($urandom_range(0, 599) == 0);
         for (int i = 0; i < NL; i++) lane_rst_req[i] = ($urandom_range(0, 299) == 0);
         if (pll_lo > 0) begin tx_pll_locked = 1'b0; pll_lo--; end
         else begin
            tx_pll_locked = 1'b1;
            if ($urandom_range(0, 249) == 0) pll_lo = $urandom_range(1, 6);
         end
         if (txc_hi > 0) begin tx_cal_busy = 1'b1; txc_hi--; end
         else begin
            tx_cal_busy = 1'b0;
            if ($urandom_range(0, 299) == 0) txc_hi = $urandom_range(1, 10);
         end
         if (rxc_hi > 0) begin rx_cal_busy = 1'b1; rxc_hi--; end
         else begin
            rx_cal_busy = 1'b0;
            if ($urandom_range(0, 199) == 0) rxc_hi = $urandom_range(1, 10);
         end
         for (int i = 0; i < NL; i++) begin
            if (ltd_lo[i] > 0) begin ltd[i] = 1'b0; ltd_lo[i]--; end
            else begin
               ltd[i] = 1'b1;
               if ($urandom_range(0, 99) == 0) ltd_lo[i] = $urandom_range(1, 20);
            end
         end
         tick();
      end
      init_start = 1'b0; lane_rst_req = '0;
      tx_pll_locked = 1'b1; tx_cal_busy = 1'b0; rx_cal_busy = 1'b0; ltd = '1;
      wait_done(200, "random_final_bringup");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hssi_lane_reset_seq.md
Name: hssi_lane_reset_seq

Overview:
- Parametrised reset/initialisation sequencer for the HSSI lanes. It sits on the AFU side and drives the per-lane analog/digital TX/RX resets from the PLL, calibration and CDR lock flags.
- Compared with the fixed four-lane single-reset scheme, it adds:
  - an independent RX state machine per lane, so one lane losing lock does not disturb the others;
  - programmable stability timers;
  - an init_start/init_done handshake.

Parameters:
- NUM_LN, 4, number of lanes (1..16).
- T_PLL_STABLE, 64, consecutive cycles tx_pll_locked=1 and tx_cal_busy=0 required before TX analog release.
- T_TX_DIG, 32, cycles between TX analog release and TX digital release.
- T_LTD_STABLE, 128, consecutive cycles rx_is_lockedtodata[i]=1 required before RX digital release.
- CNT_W, 16, timer width; must satisfy 2^CNT_W > max(T_*).

Ports:
- clk  in  1  sequencer clock
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  single-cycle pulse; restarts the full sequence on all lanes
- init_done  out  1  1 when TX and all RX lanes are ready
- lane_rst_req  in  NUM_LN  per-lane RX restart pulse
- tx_pll_locked  in  1  async, from transceiver
- tx_cal_busy  in  1  async
- rx_cal_busy  in  1  async
- rx_is_lockedtodata  in  NUM_LN  async, per lane
- tx_analogreset  out  NUM_LN  all bits identical
- tx_digitalreset  out  NUM_LN  all bits identical
- rx_analogreset  out  NUM_LN
- rx_digitalreset  out  NUM_LN
- tx_ready  out  1
- rx_ready  out  NUM_LN

Behaviour:
- Clock/reset: single clock domain, clk. rst_n is asynchronous, active-low. Assertion is immediate; deassertion is used as-is (the external reset synchroniser is a platform responsibility).
- Input synchronisers: every async input passes through a 2-flop synchroniser. All conditions below use the synchronised values.
- Reset values:
  - all reset outputs all-ones;
  - tx_ready=0, rx_ready=0, init_done=0;
  - all FSMs in their RESET state; counters 0.
- Outputs are registered, decoded from the FSM state.
- TX FSM (shared across lanes):
  - TX_RESET: analog=1, digital=1. Counter increments while pll_locked & !tx_cal_busy, otherwise clears. When counter reaches T_PLL_STABLE-1 with the condition true -> TX_ANA_REL.
  - TX_ANA_REL: analog=0, digital=1. Counts T_TX_DIG cycles -> TX_READY.
  - TX_READY: both resets 0, tx_ready=1.
  - From TX_ANA_REL or TX_READY: pll_locked=0 -> TX_RESET, counter cleared.
- RX FSM (one per lane i):
  - RX_RESET: analog=1, digital=1. Leaves when tx_ready=1 and rx_cal_busy=0 -> RX_WAIT_LTD.
  - RX_WAIT_LTD: analog=0, digital=1. Counter increments while lockedtodata[i]=1, clears on 0. At T_LTD_STABLE-1 -> RX_READY.
  - RX_READY: both resets 0, rx_ready[i]=1. lockedtodata[i]=0 -> RX_RESET.
  - From any state: tx_ready falling -> RX_RESET.
- Simultaneous events, highest priority first: rst_n, then init_start (all FSMs -> RESET on the next edge), then lane_rst_req[i] (lane i only), then lock-loss transitions.
- init_start:
  - Arriving while a sequence is in progress restarts it.
  - init_done is registered: (tx_ready & all rx_ready). It drops in the cycle after any contributing ready drops.
- Latency: a condition becoming stable at the pin changes the corresponding output exactly T+3 cycles later (2 synchroniser cycles + T counting cycles + 1 output register cycle).
- Counters never wrap: they stop at their terminal value. CNT_W sizing is checked by a synthesis-time assertion.

Optional Feature:
- Macro: HSSI_RESET_SEQ_RELOCK_CNT_EN.
- When defined:
  - adds output relock_cnt, NUM_LN*8 bits;
  - per-lane 8-bit saturating counter, incremented on each RX_READY->RX_RESET transition caused by lock loss (not by init_start or lane_rst_req);
  - cleared by rst_n and by init_start;
  - saturates at 255.
- When undefined: the port and the counters are absent, and sequencing behaviour is identical.

Test Plan (NUM_LN=4, T_PLL_STABLE=8, T_TX_DIG=4, T_LTD_STABLE=16):
- Reset then nominal bring-up:
  - Stimulus: pll_locked rises at cycle 0, cal_busy=0, all lockedtodata=1.
  - Response: tx_analogreset=0 at cycle 11; tx_digitalreset=0 and tx_ready=1 at cycle 15; rx_ready=4'hF before init_done; init_done=1 one cycle after the last rx_ready.
- PLL glitch during the stability wait:
  - Stimulus: pll_locked drops for 1 cycle at cycle 5.
  - Response: the counter restarts; tx_analogreset stays 1 until 11 cycles after the relock.
- Lane 2 loses lock in RX_READY for 3 cycles.
  - Response: only rx_digitalreset[2]/rx_analogreset[2] reassert; lanes 0, 1 and 3 stay ready; init_done drops, then returns after the lane 2 relock plus 19 cycles; relock_cnt lane 2 = 1 when HSSI_RESET_SEQ_RELOCK_CNT_EN is defined.
- init_start and lane_rst_req[1] in the same cycle while fully ready.
  - Response: all outputs return to the reset state on the next edge; the full sequence repeats; relock counters read 0.
- rst_n asserted mid-sequence (TX_ANA_REL).
  - Response: outputs go to reset values immediately (asynchronously, without a clock edge); after release the sequence restarts from TX_RESET.
